// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment readback path.
// Segment patterns are active-low, bit6..bit0 = g..a.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_ERR   = 4'hE;

  typedef enum logic {COLLECT, HOLD} state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational inverse of the display encoder: one active-low pattern in,
// 4-bit code out. A blank digit is legal; anything unrecognised flags err.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       err
);

  always_comb begin
    code = CODE_ERR;
    err  = 1'b0;
    case (seg)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = CODE_BLANK;
      default: begin
        code = CODE_ERR;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_frame_decoder.sv
// Collects NUM_DIGITS decoded 7-seg digits (HEX0 first) into one BCD frame,
// holds it until the consumer takes it, and aborts frames that stall.
module seg7_frame_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 6,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [4*NUM_DIGITS-1:0] bcd_frame,
  output logic                    frame_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    timeout_err
);

  localparam int DW = $clog2(NUM_DIGITS);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  state_t          state, next_state;
  logic [DW-1:0]   digit_cnt;
  logic [IW-1:0]   idle_cnt;
  logic [3:0]      dec_code;
  logic            dec_err;
  logic            accept;
  logic            last_digit;
  logic            timeout_hit;

  seg7_decode u_decode (
    .seg  (seg_in),
    .code (dec_code),
    .err  (dec_err)
  );

  assign accept     = in_valid & in_ready;
  assign last_digit = (digit_cnt == DW'(NUM_DIGITS - 1));
  // The idle edge that would bring idle_cnt up to the limit aborts the frame instead.
  assign timeout_hit = (state == COLLECT) && !accept && (digit_cnt != '0) &&
                       (idle_cnt == IW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= COLLECT;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      COLLECT: if (accept && last_digit) next_state = HOLD;
      HOLD:    if (out_ready)            next_state = COLLECT;
      default: next_state = COLLECT;
    endcase
  end

  always_comb begin
    in_ready  = (state == COLLECT);
    out_valid = (state == HOLD);
  end

  // Frame register and counters; bcd_frame is only ever overwritten digit by digit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_cnt   <= '0;
      idle_cnt    <= '0;
      bcd_frame   <= '0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= timeout_hit;
      if (state == HOLD) begin
        if (out_ready) begin
          digit_cnt <= '0;
          idle_cnt  <= '0;
          frame_err <= 1'b0;
        end
      end else if (accept) begin
        bcd_frame[{digit_cnt, 2'b00} +: 4] <= dec_code;
        frame_err <= frame_err | dec_err;
        digit_cnt <= digit_cnt + DW'(1);
        idle_cnt  <= '0;
      end else if (timeout_hit) begin
        digit_cnt <= '0;
        idle_cnt  <= '0;
        frame_err <= 1'b0;
      end else if (digit_cnt != '0) begin
        idle_cnt <= idle_cnt + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Directed bench for seg7_frame_decoder with TIMEOUT_CYCLES=8; every
// expected value below is worked out by hand from the decode table.
module tb_seg7_frame_decoder;
  import seg7_pkg::*;

  logic        clk;
  logic        reset;
  logic [6:0]  seg_in;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] bcd_frame;
  logic        frame_err;
  logic        out_valid;
  logic        out_ready;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  seg7_frame_decoder #(.NUM_DIGITS(6), .TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_in      (seg_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .bcd_frame   (bcd_frame),
    .frame_err   (frame_err),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .timeout_err (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [6:0] seg);
    in_valid = 1'b1;
    seg_in   = seg;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [23:0] held;
    logic        seen_pulse;

    reset     = 1'b0;
    seg_in    = SEG_BLANK;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    #1 reset = 1'b1;
    #1;
    check_output("rst_out_valid", 32'(out_valid), 32'h0);
    check_output("rst_in_ready", 32'(in_ready), 32'h1);
    check_output("rst_frame", 32'(bcd_frame), 32'h0);
    check_output("rst_timeout", 32'(timeout_err), 32'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    $display("[TB] clean frame 1..6");
    apply_stimulus(SEG_1);
    apply_stimulus(SEG_2);
    apply_stimulus(SEG_3);
    apply_stimulus(SEG_4);
    apply_stimulus(SEG_5);
    check_output("pre_last_valid", 32'(out_valid), 32'h0);
    apply_stimulus(SEG_6);
    check_output("f1_valid", 32'(out_valid), 32'h1);
    check_output("f1_frame", 32'(bcd_frame), 32'h654321);
    check_output("f1_err", 32'(frame_err), 32'h0);

    $display("[TB] backpressure in HOLD");
    in_valid = 1'b1;
    seg_in   = SEG_8;
    for (int i = 0; i < 5; i++) tick();
    check_output("hold_in_ready", 32'(in_ready), 32'h0);
    check_output("hold_valid", 32'(out_valid), 32'h1);
    check_output("hold_frame", 32'(bcd_frame), 32'h654321);
    check_output("hold_timeout", 32'(timeout_err), 32'h0);
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_output("rel_valid", 32'(out_valid), 32'h0);
    check_output("rel_in_ready", 32'(in_ready), 32'h1);
    check_output("rel_err", 32'(frame_err), 32'h0);

    $display("[TB] frame with blank and bad pattern");
    apply_stimulus(SEG_7);
    apply_stimulus(SEG_BLANK);
    apply_stimulus(7'b0000001);
    apply_stimulus(SEG_0);
    apply_stimulus(SEG_0);
    apply_stimulus(SEG_0);
    check_output("f2_valid", 32'(out_valid), 32'h1);
    check_output("f2_frame", 32'(bcd_frame), 32'h000EF7);
    check_output("f2_err", 32'(frame_err), 32'h1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_output("f2_rel_err", 32'(frame_err), 32'h0);

    apply_stimulus(SEG_0);
    apply_stimulus(SEG_1);
    apply_stimulus(SEG_2);
    apply_stimulus(SEG_3);
    apply_stimulus(SEG_4);
    apply_stimulus(SEG_5);
    check_output("f3_frame", 32'(bcd_frame), 32'h543210);
    check_output("f3_err", 32'(frame_err), 32'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    $display("[TB] stalled frame times out");
    apply_stimulus(SEG_1);
    apply_stimulus(SEG_2);
    apply_stimulus(SEG_3);
    seen_pulse = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      seen_pulse = seen_pulse | timeout_err;
    end
    check_output("to_early", 32'(seen_pulse), 32'h0);
    tick();
    check_output("to_pulse", 32'(timeout_err), 32'h1);
    check_output("to_no_frame", 32'(out_valid), 32'h0);
    tick();
    check_output("to_one_cycle", 32'(timeout_err), 32'h0);

    apply_stimulus(SEG_9);
    apply_stimulus(SEG_8);
    apply_stimulus(SEG_7);
    apply_stimulus(SEG_6);
    apply_stimulus(SEG_5);
    apply_stimulus(SEG_4);
    check_output("f4_valid", 32'(out_valid), 32'h1);
    check_output("f4_frame", 32'(bcd_frame), 32'h456789);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    $display("[TB] accept on the limit cycle beats the timeout");
    apply_stimulus(SEG_3);
    apply_stimulus(SEG_3);
    seen_pulse = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      seen_pulse = seen_pulse | timeout_err;
    end
    apply_stimulus(SEG_2);
    seen_pulse = seen_pulse | timeout_err;
    check_output("race_no_timeout", 32'(seen_pulse), 32'h0);
    apply_stimulus(SEG_1);
    apply_stimulus(SEG_1);
    apply_stimulus(SEG_1);
    check_output("race_valid", 32'(out_valid), 32'h1);
    check_output("race_frame", 32'(bcd_frame), 32'h111233);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    $display("[TB] async reset mid-frame");
    apply_stimulus(SEG_9);
    apply_stimulus(SEG_9);
    apply_stimulus(SEG_9);
    apply_stimulus(SEG_9);
    #2 reset = 1'b1;
    #1;
    check_output("mid_rst_frame", 32'(bcd_frame), 32'h0);
    check_output("mid_rst_ready", 32'(in_ready), 32'h1);
    #1 reset = 1'b0;
    tick();
    apply_stimulus(SEG_2);
    apply_stimulus(SEG_4);
    apply_stimulus(SEG_6);
    apply_stimulus(SEG_8);
    apply_stimulus(SEG_0);
    apply_stimulus(SEG_1);
    check_output("f5_valid", 32'(out_valid), 32'h1);
    check_output("f5_frame", 32'(bcd_frame), 32'h108642);
    held = bcd_frame;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    seen_pulse = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen_pulse = seen_pulse | out_valid | timeout_err;
    end
    check_output("f5_single_frame", 32'(seen_pulse), 32'h0);
    check_output("f5_frame_kept", 32'(bcd_frame), 32'(held));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
